wb_test_monitor: RTL and testbench

//  Synthesizable, parametrised self-check monitor for CPU assembly tests.
//  - Snoops the register-file write-back port.
//  - Shadows up to NUM_CHECKS watched registers.
//  - On a flag-register write of flag_val, compares each shadow against its expected value.
//  - Reports pass/fail/timeout, so on-FPGA and simulation runs share one checker.

---
 rtl/wb_test_monitor.sv | 158 +++++++++++++++
 tb/tb_wb_test_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_test_monitor.sv
// Self-check monitor for CPU assembly tests.
// Shadows the watched registers from the register-file write-back port.
// When the flag register is written with flag_val, it compares each shadow
// against its expected value, one per cycle, and reports PASS, FAIL or TIMEOUT.
module wb_test_monitor #(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [XLEN-1:0]            flag_val,
    input  logic [5*NUM_CHECKS-1:0]    chk_reg,
    input  logic [XLEN*NUM_CHECKS-1:0] chk_val,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [4:0]                 fail_idx,
    output logic [XLEN-1:0]            fail_got,
    output logic [31:0]                cycle_cnt
);

    localparam int              IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [31:0]     TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      FLAG_ADDR = 5'(FLAG_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         w_chk_reg [NUM_CHECKS];
    logic [XLEN-1:0]    w_chk_val [NUM_CHECKS];
    logic [XLEN-1:0]    r_shadow  [NUM_CHECKS];
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_cnt;
    logic [4:0]         r_fail_idx;
    logic [XLEN-1:0]    r_fail_got;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;

    logic               w_start_run;
    logic               w_trigger;
    logic               w_expire;
    logic               w_mismatch;
    logic [XLEN-1:0]    w_cur_shadow;

    for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_unpack
        assign w_chk_reg[gi] = chk_reg[5*gi +: 5];
        assign w_chk_val[gi] = chk_val[XLEN*gi +: XLEN];
    end

    // start only matters from IDLE or a terminal state; it is ignored in RUN/CHECK.
    assign w_start_run  = start && (r_state inside {S_IDLE, S_PASS, S_FAIL, S_TIMEOUT});
    assign w_trigger    = (r_state == S_RUN) && wb_we && (wb_rd == FLAG_ADDR) && (wb_data == flag_val);
    // The timer reaches TIMEOUT_CYCLES on the edge where it currently holds TIMEOUT_CYCLES-1.
    assign w_expire     = (r_state == S_RUN) && (r_cnt == TO_LAST);
    assign w_cur_shadow = r_shadow[r_idx];
    assign w_mismatch   = (w_cur_shadow != w_chk_val[r_idx]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; a trigger on the expiry cycle takes precedence over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_trigger)     w_state_nxt = S_CHECK;
                else if (w_expire) w_state_nxt = S_TIMEOUT;
            end
            S_CHECK: begin
                if (w_mismatch)             w_state_nxt = S_FAIL;
                else if (r_idx == LAST_IDX) w_state_nxt = S_PASS;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shadows, RUN cycle counter and compare index; shadows only move while running.
    always_ff @(posedge clk) begin
        if (!rst || w_start_run) begin
            for (int i = 0; i < NUM_CHECKS; i++) r_shadow[i] <= '0;
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (wb_we && (wb_rd != 5'd0) && (wb_rd == w_chk_reg[i])) r_shadow[i] <= wb_data;
            end
            r_idx <= '0;
        end else if ((r_state == S_CHECK) && !w_mismatch && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Capture the first mismatching check for reporting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fail_idx <= '0;
            r_fail_got <= '0;
        end else if ((r_state == S_CHECK) && w_mismatch) begin
            r_fail_idx <= 5'(r_idx);
            r_fail_got <= w_cur_shadow;
        end
    end

    // Registered status outputs decoded from the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_busy    <= (r_state == S_RUN) || (r_state == S_CHECK);
            r_done    <= (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
            r_pass    <= (r_state == S_PASS);
            r_fail    <= (r_state == S_FAIL);
            r_timeout <= (r_state == S_TIMEOUT);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign fail_idx  = r_fail_idx;
    assign fail_got  = r_fail_got;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_wb_test_monitor.sv
// Bench for wb_test_monitor: directed scenarios plus randomized rounds,
// checked against a register-level reference model of the monitor.
module tb_wb_test_monitor;

    localparam int XLEN = 32;
    localparam int NC   = 2;
    localparam int FLAG = 20;
    localparam int TO   = 50;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              start    = 1'b0;
    logic              wb_we    = 1'b0;
    logic [4:0]        wb_rd    = '0;
    logic [XLEN-1:0]   wb_data  = '0;
    logic [XLEN-1:0]   flag_val = 32'd1;
    logic [5*NC-1:0]   chk_reg  = '0;
    logic [XLEN*NC-1:0] chk_val = '0;
    logic              busy, done, pass, fail, timeout;
    logic [4:0]        fail_idx;
    logic [XLEN-1:0]   fail_got;
    logic [31:0]       cycle_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [4:0]      m_reg [NC];
    logic [XLEN-1:0] m_val [NC];
    logic [XLEN-1:0] m_sh  [NC];
    bit              m_run    = 1'b0;
    int              m_cycles = 0;

    wb_test_monitor #(
        .XLEN(XLEN), .NUM_CHECKS(NC), .FLAG_REG(FLAG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .flag_val(flag_val), .chk_reg(chk_reg), .chk_val(chk_val),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_idx(fail_idx), .fail_got(fail_got), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [4:0] r0, input logic [4:0] r1,
                           input logic [XLEN-1:0] v0, input logic [XLEN-1:0] v1);
        m_reg[0] = r0; m_reg[1] = r1;
        m_val[0] = v0; m_val[1] = v1;
        for (int i = 0; i < NC; i++) begin
            chk_reg[5*i +: 5]       = m_reg[i];
            chk_val[XLEN*i +: XLEN] = m_val[i];
        end
    endtask

    // One clock with a write-back beat; the model applies the monitor's rules.
    task automatic step(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_we = we; wb_rd = rd; wb_data = d;
        @(posedge clk);
        if (m_run) begin
            m_cycles++;
            if (we && rd != 5'd0)
                for (int i = 0; i < NC; i++) if (rd == m_reg[i]) m_sh[i] = d;
            if (we && rd == 5'(FLAG) && d == flag_val) m_run = 1'b0;
            else if (m_cycles == TO) m_run = 1'b0;
        end
        @(negedge clk);
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk);
        m_run = 1'b1;
        m_cycles = 0;
        for (int i = 0; i < NC; i++) m_sh[i] = '0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".cnt0"}, cycle_cnt, 32'd0);
    endtask

    // Called right after the trigger write: predicts verdict and its latency.
    task automatic expect_outcome(input string tag);
        int k;
        k = -1;
        for (int i = 0; i < NC; i++) if (k < 0 && m_sh[i] !== m_val[i]) k = i;
        if (k < 0) begin
            for (int c = 0; c < NC; c++) begin
                step(1'b0, 5'd0, '0);
                chk({tag, ".pend_done"}, 32'(done), 32'd0);
            end
            step(1'b0, 5'd0, '0);
            chk({tag, ".pass"}, 32'(pass), 32'd1);
            chk({tag, ".fail"}, 32'(fail), 32'd0);
            chk({tag, ".timeout"}, 32'(timeout), 32'd0);
            chk({tag, ".busy"}, 32'(busy), 32'd0);
        end else begin
            for (int c = 0; c <= k; c++) begin
                step(1'b0, 5'd0, '0);
                chk({tag, ".pend_done"}, 32'(done), 32'd0);
            end
            step(1'b0, 5'd0, '0);
            chk({tag, ".fail"}, 32'(fail), 32'd1);
            chk({tag, ".pass"}, 32'(pass), 32'd0);
            chk({tag, ".fail_idx"}, 32'(fail_idx), 32'(k));
            chk({tag, ".fail_got"}, fail_got, m_sh[k]);
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".cycle_cnt"}, cycle_cnt, 32'(m_cycles));
    endtask

    initial begin
        logic [4:0] pool [5];
        logic [4:0] rd;
        logic [XLEN-1:0] d;
        pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2; pool[3] = 5'd3; pool[4] = 5'd20;

        // Power-on reset
        rst = 1'b0;
        step(1'b0, 5'd0, '0);
        step(1'b0, 5'd0, '0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.fail", 32'(fail), 32'd0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        chk("rst.fail_idx", 32'(fail_idx), 32'd0);
        chk("rst.fail_got", fail_got, 32'd0);
        chk("rst.cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b1;

        // Basic pass; a start pulse during RUN must be ignored
        set_cfg(5'd1, 5'd2, 32'd300, 32'd100);
        do_start("t2");
        step(1'b0, 5'd0, '0);
        chk("t2.busy", 32'(busy), 32'd1);
        step(1'b1, 5'd1, 32'd300);
        start = 1'b1;
        step(1'b1, 5'd2, 32'd100);
        start = 1'b0;
        step(1'b1, 5'd20, 32'd1);
        expect_outcome("t2");

        // Mismatch on check 1
        do_start("t3");
        step(1'b1, 5'd1, 32'd300);
        step(1'b1, 5'd2, 32'd99);
        step(1'b1, 5'd20, 32'd1);
        expect_outcome("t3");

        // Last write wins, x0 ignored
        do_start("t4");
        step(1'b1, 5'd1, 32'd5);
        step(1'b1, 5'd1, 32'd300);
        step(1'b1, 5'd0, 32'd7);
        step(1'b1, 5'd2, 32'd100);
        step(1'b1, 5'd20, 32'd1);
        expect_outcome("t4");

        // Watched x0 always reads 0
        set_cfg(5'd1, 5'd0, 32'd300, 32'd7);
        do_start("t4z");
        step(1'b1, 5'd1, 32'd300);
        step(1'b1, 5'd0, 32'd7);
        step(1'b1, 5'd20, 32'd1);
        expect_outcome("t4z");

        // Reset in the middle of CHECK
        set_cfg(5'd1, 5'd2, 32'd300, 32'd100);
        do_start("t1");
        step(1'b1, 5'd1, 32'd300);
        step(1'b1, 5'd2, 32'd100);
        step(1'b1, 5'd20, 32'd1);
        rst = 1'b0;
        step(1'b0, 5'd0, '0);
        rst = 1'b1;
        m_run = 1'b0;
        chk("t1.busy", 32'(busy), 32'd0);
        chk("t1.done", 32'(done), 32'd0);
        chk("t1.pass", 32'(pass), 32'd0);
        chk("t1.fail", 32'(fail), 32'd0);
        chk("t1.cycle_cnt", cycle_cnt, 32'd0);
        for (int c = 0; c < 4; c++) step(1'b0, 5'd0, '0);
        chk("t1.idle_pass", 32'(pass), 32'd0);
        chk("t1.idle_busy", 32'(busy), 32'd0);

        // Timeout after TO RUN cycles
        do_start("t5");
        for (int c = 0; c < TO; c++) begin
            step(1'b0, 5'd0, '0);
            chk("t5.no_timeout", 32'(timeout), 32'd0);
        end
        step(1'b0, 5'd0, '0);
        chk("t5.timeout", 32'(timeout), 32'd1);
        chk("t5.done", 32'(done), 32'd1);
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.cycle_cnt", cycle_cnt, 32'(TO));
        do_start("t5r");
        step(1'b0, 5'd0, '0);
        chk("t5r.busy", 32'(busy), 32'd1);
        chk("t5r.timeout", 32'(timeout), 32'd0);

        // Wrong flag value, then trigger exactly on the expiry cycle
        step(1'b1, 5'd20, 32'd2);
        step(1'b0, 5'd0, '0);
        chk("t6.still_run", 32'(busy), 32'd1);
        step(1'b1, 5'd1, 32'd300);
        step(1'b1, 5'd2, 32'd100);
        while (m_cycles < TO - 1) step(1'b0, 5'd0, '0);
        step(1'b1, 5'd20, 32'd1);
        expect_outcome("t6");

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            flag_val = 32'($urandom_range(1, 3));
            set_cfg(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                    32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
            do_start($sformatf("rnd%0d", r));
            for (int w = 0; w < 6; w++) begin
                rd = ($urandom_range(0, 5) == 5) ? 5'd7 : pool[$urandom_range(0, 4)];
                d  = 32'($urandom_range(0, 3));
                if (rd == 5'(FLAG) && d == flag_val) d = 32'd4;
                step(1'b1, rd, d);
            end
            step(1'b1, 5'(FLAG), flag_val);
            expect_outcome($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
